mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/arb_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the arbiter and its environment (two caches plus memory).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              req0_enable_i;
  logic              req0_write_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [LINE_W-1:0] req0_data_i;
  logic              req0_ack_o;
  logic [LINE_W-1:0] req0_data_o;

  logic              req1_enable_i;
  logic              req1_write_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [LINE_W-1:0] req1_data_i;
  logic              req1_ack_o;
  logic [LINE_W-1:0] req1_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;

  // Handshake: a requester raises enable with a stable payload and holds both
  // until its ack pulse; memory holds mem_ack_i high for the completing cycle.
  modport master (
    input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    input  mem_ack_i, mem_data_i,
    output req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
    output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
    output mem_ack_i, mem_data_i,
    input  req0_ack_o, req0_data_o, req1_ack_o, req1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/arb_pick2.sv
// Two-way winner selection. With MEM_ARB_RR_EN a tie goes to prio_i,
// otherwise requester 0 always wins a tie.
module arb_pick2 (
  input  logic req0_i,
  input  logic req1_i,
`ifdef MEM_ARB_RR_EN
  input  logic prio_i,
`endif
  output logic vld_o,
  output logic gnt_o
);

  always_comb begin
    vld_o = req0_i | req1_i;
`ifdef MEM_ARB_RR_EN
    gnt_o = req0_i ? (req1_i ? prio_i : 1'b0) : 1'b1;
`else
    gnt_o = ~req0_i;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between data cache (req0) and instruction cache (req1).
// Define MEM_ARB_RR_EN for round-robin ties; default build is fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [LINE_W-1:0] req0_data_o,

  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [LINE_W-1:0] req1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,

  output arb_state_e        dbg_state_o
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic              pick_vld, pick_gnt;

`ifdef MEM_ARB_RR_EN
  // prio_q names the requester that wins the next tie.
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (state_q == ST_IDLE && pick_vld) prio_d = ~pick_gnt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

  arb_pick2 u_pick (
    .req0_i (req0_enable_i),
    .req1_i (req1_enable_i),
`ifdef MEM_ARB_RR_EN
    .prio_i (prio_q),
`endif
    .vld_o  (pick_vld),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d    = ST_BUSY;
          grant_d    = pick_gnt;
          mem_en_d   = 1'b1;
          mem_wr_d   = pick_gnt ? req1_write_i : req0_write_i;
          mem_addr_d = pick_gnt ? req1_addr_i  : req0_addr_i;
          mem_data_d = pick_gnt ? req1_data_i  : req0_data_i;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d  = ST_RELEASE;
          mem_en_d = 1'b0;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Acks are combinational from memory and gated so only the granted side sees one.
  assign req0_ack_o   = (state_q == ST_BUSY) && mem_ack_i && !grant_q;
  assign req1_ack_o   = (state_q == ST_BUSY) && mem_ack_i &&  grant_q;
  assign req0_data_o  = mem_data_i;
  assign req1_data_o  = mem_data_i;

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow the build's MEM_ARB_RR_EN setting.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic clk;
  logic rst_i;
  arb_state_e dbg_state;
  int n_vec = 0;
  int n_err = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req0_enable_i (bus.req0_enable_i),
    .req0_write_i  (bus.req0_write_i),
    .req0_addr_i   (bus.req0_addr_i),
    .req0_data_i   (bus.req0_data_i),
    .req0_ack_o    (bus.req0_ack_o),
    .req0_data_o   (bus.req0_data_o),
    .req1_enable_i (bus.req1_enable_i),
    .req1_write_i  (bus.req1_write_i),
    .req1_addr_i   (bus.req1_addr_i),
    .req1_data_i   (bus.req1_data_i),
    .req1_ack_o    (bus.req1_ack_o),
    .req1_data_o   (bus.req1_data_o),
    .mem_enable_o  (bus.mem_enable_o),
    .mem_write_o   (bus.mem_write_o),
    .mem_addr_o    (bus.mem_addr_o),
    .mem_data_o    (bus.mem_data_o),
    .mem_ack_i     (bus.mem_ack_i),
    .mem_data_i    (bus.mem_data_i),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clear_inputs();
    bus.req0_enable_i = 1'b0; bus.req0_write_i = 1'b0;
    bus.req0_addr_i   = '0;   bus.req0_data_i  = '0;
    bus.req1_enable_i = 1'b0; bus.req1_write_i = 1'b0;
    bus.req1_addr_i   = '0;   bus.req1_data_i  = '0;
    bus.mem_ack_i     = 1'b0; bus.mem_data_i   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic wait_mem_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mem_enable_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: en=%b wr=%b, want 0 0", bus.mem_enable_o, bus.mem_write_o);
    end
    n_vec++;
    if (bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== '0) begin
      n_err++; $display("FAIL reset_bus: addr=%h data=%h, want 0", bus.mem_addr_o, bus.mem_data_o);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_read();
    bit ok;
    // Release reset and request in the same cycle: grant at the very next edge.
    @(negedge clk);
    rst_i = 1'b1;
    bus.req0_enable_i = 1'b1; bus.req0_write_i = 1'b0; bus.req0_addr_i = 32'h0;
    @(negedge clk);
    n_vec++;
    if (bus.mem_enable_o !== 1'b1 || dbg_state !== ST_BUSY) begin
      n_err++; $display("FAIL read_grant_latency: en=%b state=%0d, want 1 %0d", bus.mem_enable_o, dbg_state, ST_BUSY);
    end
    n_vec++;
    if (bus.mem_addr_o !== 32'h0 || bus.mem_write_o !== 1'b0) begin
      n_err++; $display("FAIL read_latch: addr=%h wr=%b, want 0 0", bus.mem_addr_o, bus.mem_write_o);
    end
    repeat (9) @(negedge clk);
    n_vec++;
    if (bus.req0_ack_o !== 1'b0 || dbg_state !== ST_BUSY) begin
      n_err++; $display("FAIL read_wait: ack=%b state=%0d, want 0 %0d", bus.req0_ack_o, dbg_state, ST_BUSY);
    end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'h5;
    #1;
    n_vec++;
    if (bus.req0_ack_o !== 1'b1 || bus.req1_ack_o !== 1'b0) begin
      n_err++; $display("FAIL read_ack: ack0=%b ack1=%b, want 1 0", bus.req0_ack_o, bus.req1_ack_o);
    end
    n_vec++;
    if (bus.req0_data_o !== 256'h5) begin
      n_err++; $display("FAIL read_data: got %h want 5", bus.req0_data_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.req0_enable_i = 1'b0;
    #1;
    n_vec++;
    if (bus.req0_ack_o !== 1'b0 || bus.mem_enable_o !== 1'b0 || dbg_state !== ST_RELEASE) begin
      n_err++; $display("FAIL read_release: ack0=%b en=%b state=%0d, want 0 0 %0d", bus.req0_ack_o, bus.mem_enable_o, dbg_state, ST_RELEASE);
    end
    @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL read_back_idle: state=%0d want %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_tie();
    bit ok;
    int low;
    apply_reset();
    bus.req0_enable_i = 1'b1; bus.req0_addr_i = 32'h20;
    bus.req1_enable_i = 1'b1; bus.req1_addr_i = 32'h400;
    wait_mem_en(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL tie_first_timeout: en=%b want 1", bus.mem_enable_o); end
    n_vec++;
    if (bus.mem_addr_o !== 32'h20) begin
      n_err++; $display("FAIL tie_first_addr: got %h want 00000020", bus.mem_addr_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'h11;
    #1;
    n_vec++;
    if (bus.req0_ack_o !== 1'b1 || bus.req1_ack_o !== 1'b0) begin
      n_err++; $display("FAIL tie_first_ack: ack0=%b ack1=%b, want 1 0", bus.req0_ack_o, bus.req1_ack_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.req0_enable_i = 1'b0;
    low = bus.mem_enable_o ? 0 : 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_enable_o) break;
      low++;
    end
    n_vec++;
    if (low != 2) begin
      n_err++; $display("FAIL tie_gap: enable low for %0d cycles, want 2", low);
    end
    n_vec++;
    if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== 32'h400) begin
      n_err++; $display("FAIL tie_second_addr: en=%b addr=%h, want 1 00000400", bus.mem_enable_o, bus.mem_addr_o);
    end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'h22;
    #1;
    n_vec++;
    if (bus.req1_ack_o !== 1'b1 || bus.req0_ack_o !== 1'b0 || bus.req1_data_o !== 256'h22) begin
      n_err++; $display("FAIL tie_second_ack: ack1=%b ack0=%b data=%h, want 1 0 22", bus.req1_ack_o, bus.req0_ack_o, bus.req1_data_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.req1_enable_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit exp_g;
    logic [ADDR_W-1:0] exp_addr;
    apply_reset();
    bus.req0_enable_i = 1'b1; bus.req0_addr_i = 32'h100;
    bus.req1_enable_i = 1'b1; bus.req1_addr_i = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = i[0];
`else
      exp_g = 1'b0;
`endif
      exp_addr = exp_g ? 32'h200 : 32'h100;
      wait_mem_en(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL b2b_timeout[%0d]: en=%b want 1", i, bus.mem_enable_o); end
      n_vec++;
      if (bus.mem_addr_o !== exp_addr) begin
        n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, bus.mem_addr_o, exp_addr);
      end
      bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'(i + 1);
      #1;
      n_vec++;
      if (bus.req0_ack_o !== !exp_g || bus.req1_ack_o !== exp_g) begin
        n_err++; $display("FAIL b2b_grant[%0d]: ack0=%b ack1=%b, want %b %b", i, bus.req0_ack_o, bus.req1_ack_o, !exp_g, exp_g);
      end
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
    end
    bus.req0_enable_i = 1'b0; bus.req1_enable_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    logic [LINE_W-1:0] a5;
    a5 = {32{8'hA5}};
    apply_reset();
    bus.req1_enable_i = 1'b1; bus.req1_write_i = 1'b1;
    bus.req1_addr_i = 32'h40; bus.req1_data_i = a5;
    wait_mem_en(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL write_timeout: en=%b want 1", bus.mem_enable_o); end
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (bus.mem_write_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin
        n_err++; $display("FAIL write_hold_ctrl[%0d]: wr=%b addr=%h, want 1 00000040", c, bus.mem_write_o, bus.mem_addr_o);
      end
      n_vec++;
      if (bus.mem_data_o !== a5) begin
        n_err++; $display("FAIL write_hold_data[%0d]: got %h want %h", c, bus.mem_data_o, a5);
      end
      // Payload changes and enable drops mid-transaction must not disturb it.
      if (c == 1) begin
        bus.req1_enable_i = 1'b0; bus.req1_data_i = '0; bus.req1_addr_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    bus.mem_ack_i = 1'b1;
    #1;
    n_vec++;
    if (bus.req1_ack_o !== 1'b1 || bus.req0_ack_o !== 1'b0 || bus.mem_data_o !== a5) begin
      n_err++; $display("FAIL write_ack: ack1=%b ack0=%b data=%h, want 1 0 a5..", bus.req1_ack_o, bus.req0_ack_o, bus.mem_data_o);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    n_vec++;
    if (bus.mem_enable_o !== 1'b0) begin
      n_err++; $display("FAIL write_release: en=%b want 0", bus.mem_enable_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_busy();
    bit ok;
    apply_reset();
    bus.req0_enable_i = 1'b1; bus.req0_write_i = 1'b1;
    bus.req0_addr_i = 32'h80; bus.req0_data_i = 256'h77;
    wait_mem_en(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstbusy_timeout: en=%b want 1", bus.mem_enable_o); end
    repeat (2) @(negedge clk);
    rst_i = 1'b0; bus.req0_enable_i = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== '0) begin
      n_err++; $display("FAIL rstbusy_outputs: en=%b wr=%b addr=%h data=%h, want all 0", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL rstbusy_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_i = 1'b1; bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'h9;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.req0_ack_o !== 1'b0 || bus.req1_ack_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
        n_err++; $display("FAIL rstbusy_late_ack[%0d]: ack0=%b ack1=%b en=%b, want 0 0 0", c, bus.req0_ack_o, bus.req1_ack_o, bus.mem_enable_o);
      end
      @(negedge clk);
    end
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    @(negedge clk);
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 256'h3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.req0_ack_o !== 1'b0 || bus.req1_ack_o !== 1'b0 || dbg_state !== ST_IDLE) begin
        n_err++; $display("FAIL spurious_ack[%0d]: ack0=%b ack1=%b state=%0d, want 0 0 %0d", c, bus.req0_ack_o, bus.req1_ack_o, dbg_state, ST_IDLE);
      end
      @(negedge clk);
    end
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_tie();
    test_back_to_back();
    test_write();
    test_reset_in_busy();
    test_spurious_ack();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
